// File: rtl/exec_stage_mc.sv
// rtl/exec_stage_mc.sv - execute stage with forwarding, registered output and optional multi-cycle multiply
// Optional feature: EXEC_MUL_EN enables the RUN/MUL FSM with a shift-add multiplier for op 0100.
module exec_stage_mc #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [REGW-1:0] rs_a,
  input  logic [REGW-1:0] rs_b,
  input  logic [REGW-1:0] rd,
  input  logic [XLEN-1:0] rd_a_data,
  input  logic [XLEN-1:0] rd_b_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic            alu_src,
  input  logic [3:0]      op,
  input  logic [4:0]      ctl,
  input  logic            wb_we,
  input  logic [REGW-1:0] wb_reg,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] br_target,
  output logic            zero,
  output logic [4:0]      out_ctl,
  output logic [REGW-1:0] out_rd
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  logic [XLEN-1:0] result_q, result_d, sd_q, sd_d, bt_q, bt_d;
  logic            zero_q, zero_d, out_valid_q, out_valid_d;
  logic [4:0]      ctl_q, ctl_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic [XLEN-1:0] a_fwd, b_fwd, b_op, alu_y, bt_y;
  logic            out_free, fire, load_alu;

  // The output register is the newest producer, so it beats the writeback stage.
  always_comb begin
    if (out_valid_q && ctl_q[0] && rd_q != '0 && rd_q == rs_a) a_fwd = result_q;
    else if (wb_we && wb_reg != '0 && wb_reg == rs_a)          a_fwd = wb_data;
    else                                                       a_fwd = rd_a_data;
  end

  always_comb begin
    if (out_valid_q && ctl_q[0] && rd_q != '0 && rd_q == rs_b) b_fwd = result_q;
    else if (wb_we && wb_reg != '0 && wb_reg == rs_b)          b_fwd = wb_data;
    else                                                       b_fwd = rd_b_data;
  end

  assign b_op = alu_src ? imm : b_fwd;
  assign bt_y = pc + (imm << 2);

  always_comb begin
    case (op)
      OP_AND:  alu_y = a_fwd & b_op;
      OP_OR:   alu_y = a_fwd | b_op;
      OP_SUB:  alu_y = a_fwd - b_op;
      OP_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(a_fwd) < $signed(b_op))};
      default: alu_y = a_fwd + b_op;
    endcase
  end

  assign out_free = !out_valid_q || out_ready;

`ifdef EXEC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b0100;
  typedef enum logic {S_RUN, S_MUL} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [XLEN-1:0] msd_q, msd_d, mbt_q, mbt_d, acc_step, prod;
  logic [4:0]      mctl_q, mctl_d;
  logic [REGW-1:0] mrd_q, mrd_d;
  logic            is_mul, mul_done;

  assign is_mul   = (op == OP_MUL);
  assign in_ready = (state_q == S_RUN) && out_free && !flush;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  // The last step's partial sum is loaded directly so the result lands XLEN edges after acceptance.
  assign prod     = (cnt_q == '0) ? acc_q : acc_step;
  assign mul_done = (cnt_q <= CW'(1));
  assign fire     = in_valid && in_ready;
  assign load_alu = fire && !is_mul;
`else
  assign in_ready = out_free && !flush;
  assign fire     = in_valid && in_ready;
  assign load_alu = fire;
`endif

  always_comb begin
    result_d    = result_q;
    sd_d        = sd_q;
    bt_d        = bt_q;
    zero_d      = zero_q;
    ctl_d       = ctl_q;
    rd_d        = rd_q;
    out_valid_d = out_valid_q;
    if (out_ready) out_valid_d = 1'b0;
    if (load_alu) begin
      result_d    = alu_y;
      zero_d      = (alu_y == '0);
      sd_d        = b_fwd;
      bt_d        = bt_y;
      ctl_d       = ctl;
      rd_d        = rd;
      out_valid_d = 1'b1;
    end
`ifdef EXEC_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    msd_d    = msd_q;
    mbt_d    = mbt_q;
    mctl_d   = mctl_q;
    mrd_d    = mrd_q;
    if (fire && is_mul) begin
      state_d  = S_MUL;
      cnt_d    = CW'(XLEN);
      mcand_d  = a_fwd;
      mplier_d = b_op;
      acc_d    = '0;
      msd_d    = b_fwd;
      mbt_d    = bt_y;
      mctl_d   = ctl;
      mrd_d    = rd;
    end
    if (state_q == S_MUL) begin
      if (cnt_q != '0) begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
      end
      if (mul_done && out_free) begin
        result_d    = prod;
        zero_d      = (prod == '0);
        sd_d        = msd_q;
        bt_d        = mbt_q;
        ctl_d       = mctl_q;
        rd_d        = mrd_q;
        out_valid_d = 1'b1;
        state_d     = S_RUN;
      end
    end
    if (flush) begin
      state_d = S_RUN;
      cnt_d   = '0;
    end
`endif
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q    <= '0;
      sd_q        <= '0;
      bt_q        <= '0;
      zero_q      <= 1'b0;
      ctl_q       <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      sd_q        <= sd_d;
      bt_q        <= bt_d;
      zero_q      <= zero_d;
      ctl_q       <= ctl_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef EXEC_MUL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      msd_q    <= '0;
      mbt_q    <= '0;
      mctl_q   <= '0;
      mrd_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      msd_q    <= msd_d;
      mbt_q    <= mbt_d;
      mctl_q   <= mctl_d;
      mrd_q    <= mrd_d;
    end
  end
`endif

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign store_data = sd_q;
  assign br_target  = bt_q;
  assign zero       = zero_q;
  assign out_ctl    = ctl_q;
  assign out_rd     = rd_q;
endmodule

// File: tb/tb_exec_stage_mc.sv
// tb/tb_exec_stage_mc.sv - self-checking bench for exec_stage_mc against an arithmetic reference model
module tb_exec_stage_mc;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready;
  logic [REGW-1:0] rs_a, rs_b, rd, wb_reg, out_rd;
  logic [XLEN-1:0] rd_a_data, rd_b_data, imm, pc, wb_data;
  logic            alu_src, wb_we, flush, out_valid, out_ready, zero;
  logic [3:0]      op;
  logic [4:0]      ctl, out_ctl;
  logic [XLEN-1:0] result, store_data, br_target;

  int n_total = 0;
  int n_pass  = 0;

  logic            m_valid, m_zero;
  logic [XLEN-1:0] m_result, m_sd, m_bt;
  logic [4:0]      m_ctl;
  logic [REGW-1:0] m_rd;

  exec_stage_mc #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .imm(imm), .pc(pc), .alu_src(alu_src), .op(op), .ctl(ctl),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .store_data(store_data),
    .br_target(br_target), .zero(zero), .out_ctl(out_ctl), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    in_valid = 0; rs_a = 0; rs_b = 0; rd = 0; rd_a_data = 0; rd_b_data = 0;
    imm = 0; pc = 0; alu_src = 0; op = 0; ctl = 0;
    wb_we = 0; wb_reg = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic drive_op(input logic [3:0] o, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rdst, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [31:0] p, input logic asrc,
                          input logic [4:0] c);
    in_valid = 1; op = o; rs_a = ra; rs_b = rb; rd = rdst; rd_a_data = a; rd_b_data = b;
    imm = im; pc = p; alu_src = asrc; ctl = c;
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (m_valid && m_ctl[0] && m_rd != 0 && m_rd == idx) return m_result;
    if (wb_we && wb_reg != 0 && wb_reg == idx) return wb_data;
    return rf;
  endfunction

  task automatic test_reset;
    set_idle();
    reset = 0;
    #12;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (result !== 32'd0) $display("FAIL reset_result got %h want 0", result); else n_pass++;
    n_total++; if ({store_data, br_target} !== 64'd0) $display("FAIL reset_sd_bt got %h %h want 0", store_data, br_target); else n_pass++;
    n_total++; if ({zero, out_ctl, out_rd} !== 11'd0) $display("FAIL reset_flags got %b %b %b want 0", zero, out_ctl, out_rd); else n_pass++;
    @(negedge clk);
    reset = 1;
    tick();
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_add;
    drive_op(4'd2, 5'd1, 5'd2, 5'd9, 32'd5, 32'd33, 32'd7, 32'h100, 1'b1, 5'b00001);
    tick();
    in_valid = 0;
    n_total++; if (result !== 32'd12) $display("FAIL add_result got %h want %h", result, 32'd12); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || zero !== 1'b0) $display("FAIL add_valid_zero got %b %b want 1 0", out_valid, zero); else n_pass++;
    n_total++; if (br_target !== 32'h11C) $display("FAIL add_br_target got %h want 11c", br_target); else n_pass++;
    n_total++; if (store_data !== 32'd33 || out_rd !== 5'd9 || out_ctl !== 5'b00001)
      $display("FAIL add_fields got %h %0d %b want 21 9 00001", store_data, out_rd, out_ctl); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL add_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    drive_op(4'd2, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 32'd0, 32'd0, 1'b0, 5'b00001);
    tick();
    drive_op(4'd6, 5'd3, 5'd6, 5'd8, 32'd99, 32'd30, 32'd0, 32'd0, 1'b0, 5'b00001);
    tick();
    in_valid = 0;
    n_total++; if (result !== 32'd0 || zero !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL b2b_sub got %h zero %b valid %b want 0 1 1", result, zero, out_valid); else n_pass++;
    tick();
  endtask

  task automatic test_wb_forward;
    drive_op(4'd2, 5'd1, 5'd2, 5'd4, 32'd2, 32'd0, 32'd0, 32'd0, 1'b1, 5'b00001);
    tick();
    wb_we = 1; wb_reg = 5'd4; wb_data = 32'd9;
    drive_op(4'd2, 5'd4, 5'd2, 5'd0, 32'd77, 32'd0, 32'd0, 32'd0, 1'b1, 5'b00001);
    tick();
    n_total++; if (result !== 32'd2) $display("FAIL fwd_stage3_priority got %h want 2", result); else n_pass++;
    tick();
    n_total++; if (result !== 32'd9) $display("FAIL fwd_wb got %h want 9", result); else n_pass++;
    wb_reg = 5'd0; wb_data = 32'd5;
    drive_op(4'd2, 5'd0, 5'd2, 5'd0, 32'd3, 32'd0, 32'd0, 32'd0, 1'b1, 5'b00001);
    tick();
    n_total++; if (result !== 32'd3) $display("FAIL fwd_reg0 got %h want 3", result); else n_pass++;
    wb_reg = 5'd4; wb_data = 32'd9;
    drive_op(4'd2, 5'd0, 5'd4, 5'd0, 32'd0, 32'd1, 32'd1, 32'd0, 1'b1, 5'b00001);
    tick();
    n_total++; if (result !== 32'd1 || store_data !== 32'd9)
      $display("FAIL fwd_store_data got %h %h want 1 9", result, store_data); else n_pass++;
    set_idle();
    tick();
  endtask

  task automatic test_backpressure;
    drive_op(4'd2, 5'd1, 5'd2, 5'd9, 32'd5, 32'd0, 32'd7, 32'd0, 1'b1, 5'b00001);
    tick();
    out_ready = 0;
    drive_op(4'd1, 5'd1, 5'd2, 5'd7, 32'hF0, 32'h0F, 32'd0, 32'd0, 1'b0, 5'b00000);
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", in_ready); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (result !== 32'd12 || out_valid !== 1'b1 || out_rd !== 5'd9)
        $display("FAIL bp_hold got %h %b %0d want 12 1 9", result, out_valid, out_rd); else n_pass++;
    end
    out_ready = 1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release got %b want 1", in_ready); else n_pass++;
    tick();
    in_valid = 0;
    n_total++; if (result !== 32'hFF || out_rd !== 5'd7) $display("FAIL bp_next got %h %0d want ff 7", result, out_rd); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush;
    drive_op(4'd2, 5'd1, 5'd2, 5'd9, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 5'b00001);
    tick();
    out_ready = 0;
    flush = 1;
    drive_op(4'd2, 5'd1, 5'd2, 5'd5, 32'd4, 32'd4, 32'd0, 32'd0, 1'b0, 5'b00001);
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready); else n_pass++;
    tick();
    flush = 0; in_valid = 0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_clear got %b want 0", out_valid); else n_pass++;
    out_ready = 1;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_no_load got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_random;
    logic [3:0]  ops [8];
    logic [31:0] a, bf, bo, y;
    logic        exp_ready;
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd4, 4'd3, 4'd15};
    set_idle();
    tick();
    m_valid = 0; m_result = 0; m_zero = 0; m_sd = 0; m_bt = 0; m_ctl = 0; m_rd = 0;
    for (int it = 0; it < 400; it++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rs_a      = REGW'($urandom_range(0, 3));
      rs_b      = REGW'($urandom_range(0, 3));
      rd        = REGW'($urandom_range(0, 3));
      rd_a_data = $urandom;
      rd_b_data = ($urandom_range(0, 7) == 0) ? rd_a_data : $urandom;
      imm       = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 8)) - 32'd4;
      pc        = $urandom;
      alu_src   = 1'($urandom_range(0, 1));
      op        = ops[$urandom_range(0, 7)];
`ifdef EXEC_MUL_EN
      if (op == 4'd4) op = 4'd2;
`endif
      ctl       = 5'($urandom);
      wb_we     = 1'($urandom_range(0, 1));
      wb_reg    = REGW'($urandom_range(0, 3));
      wb_data   = $urandom;
      #1;
      exp_ready = !flush && (!m_valid || out_ready);
      n_total++; if (in_ready !== exp_ready) $display("FAIL rand_in_ready it %0d got %b want %b", it, in_ready, exp_ready); else n_pass++;
      if (flush) m_valid = 0;
      else if (in_valid && exp_ready) begin
        a  = fwd(rs_a, rd_a_data);
        bf = fwd(rs_b, rd_b_data);
        bo = alu_src ? imm : bf;
        y  = ref_alu(op, a, bo);
        m_result = y; m_zero = (y == 0); m_sd = bf; m_bt = pc + imm * 4;
        m_ctl = ctl; m_rd = rd; m_valid = 1;
      end else if (out_ready) m_valid = 0;
      tick();
      n_total++; if (out_valid !== m_valid) $display("FAIL rand_out_valid it %0d got %b want %b", it, out_valid, m_valid); else n_pass++;
      if (m_valid) begin
        n_total++;
        if (result !== m_result || zero !== m_zero || store_data !== m_sd || br_target !== m_bt || out_ctl !== m_ctl || out_rd !== m_rd)
          $display("FAIL rand_out it %0d got %h %b %h %h %b %0d want %h %b %h %h %b %0d", it,
                   result, zero, store_data, br_target, out_ctl, out_rd, m_result, m_zero, m_sd, m_bt, m_ctl, m_rd);
        else n_pass++;
      end
    end
    set_idle();
    tick();
  endtask

  task automatic test_async_reset;
    drive_op(4'd2, 5'd1, 5'd2, 5'd9, 32'd5, 32'd0, 32'd7, 32'd0, 1'b1, 5'b00001);
    out_ready = 0;
    tick();
    in_valid = 0;
    #3 reset = 0;
    #1;
    n_total++; if (out_valid !== 1'b0 || result !== 32'd0 || out_rd !== 5'd0)
      $display("FAIL async_reset got %b %h %0d want 0 0 0", out_valid, result, out_rd); else n_pass++;
    #2 reset = 1;
    out_ready = 1;
    tick();
    n_total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL async_release got %b %b want 1 0", in_ready, out_valid); else n_pass++;
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul;
    int bad_ready, waited;
    logic [31:0] a, b;
    set_idle();
    tick();
    drive_op(4'd4, 5'd1, 5'd2, 5'd10, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1'b0, 5'b00001);
    tick();
    in_valid = 0;
    bad_ready = 0;
    for (int i = 0; i < 32; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad_ready++;
      tick();
    end
    n_total++; if (bad_ready != 0) $display("FAIL mul_busy got %0d busy violations want 0", bad_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFD || out_rd !== 5'd10)
      $display("FAIL mul_result got %b %h %0d want 1 fffffffd 10", out_valid, result, out_rd); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL mul_run got %b want 1", in_ready); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b = $urandom;
      if (k == 0) b = 32'd0;
      set_idle();
      tick();
      drive_op(4'd4, 5'd1, 5'd2, 5'd11, a, b, 32'd0, 32'd0, 1'b0, 5'b00001);
      tick();
      in_valid = 0;
      out_ready = 0;
      waited = 0;
      while (out_valid !== 1'b1 && waited < 40) begin
        tick();
        waited++;
      end
      n_total++; if (waited != 32) $display("FAIL mul_latency got %0d want 32", waited); else n_pass++;
      tick();
      n_total++; if (result !== a * b || zero !== (a * b == 0) || out_valid !== 1'b1)
        $display("FAIL mul_rand got %h %b %b want %h", result, zero, out_valid, a * b); else n_pass++;
    end
    set_idle();
    tick();
  endtask

  task automatic test_mul_flush;
    int spurious;
    drive_op(4'd4, 5'd1, 5'd2, 5'd10, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, 5'b00001);
    tick();
    in_valid = 0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1;
    tick();
    flush = 0;
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mul_flush got %b %b want 0 1", out_valid, in_ready); else n_pass++;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) spurious++;
      tick();
    end
    n_total++; if (spurious != 0) $display("FAIL mul_flush_emit got %0d want 0", spurious); else n_pass++;
    drive_op(4'd4, 5'd1, 5'd2, 5'd10, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, 5'b00001);
    tick();
    in_valid = 0;
    for (int i = 0; i < 5; i++) tick();
    #3 reset = 0;
    #1;
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mul_reset got %b %b want 0 1", out_valid, in_ready); else n_pass++;
    #2 reset = 1;
    tick();
    n_total++; if (in_ready !== 1'b1) $display("FAIL mul_reset_release got %b want 1", in_ready); else n_pass++;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) spurious++;
      tick();
    end
    n_total++; if (spurious != 0) $display("FAIL mul_reset_emit got %0d want 0", spurious); else n_pass++;
  endtask
`else
  task automatic test_mul_as_add;
    set_idle();
    tick();
    drive_op(4'd4, 5'd1, 5'd2, 5'd10, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'd0, 1'b0, 5'b00001);
    tick();
    in_valid = 0;
    n_total++; if (out_valid !== 1'b1 || result !== 32'd2) $display("FAIL mul_as_add got %b %h want 1 2", out_valid, result); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL mul_as_add_ready got %b want 1", in_ready); else n_pass++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_wb_forward();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
`ifdef EXEC_MUL_EN
    test_mul();
    test_mul_flush();
`else
    test_mul_as_add();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/exec_stage_mc.md
EXEC_STAGE_MC -- requirements
Module: exec_stage_mc

Interface
REQ-001 SHALL provide parameter XLEN, 32, datapath width (>=8).
REQ-002 SHALL provide parameter REGW, 5, register-index width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid in 1 / in_ready out 1: decode-side handshake.
REQ-006 SHALL have ports rs_a, rs_b, rd  in  REGW: source A, source B, destination index.
REQ-007 SHALL have ports rd_a_data, rd_b_data, imm, pc  in  XLEN: register-file operands, sign-extended immediate, PC+4.
REQ-008 SHALL have ports alu_src in 1 (1 selects imm as B) and op in 4 (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 0100 MUL).
REQ-009 SHALL have port ctl  in  5  {Branch, MemWrite, MemRead, MemtoReg, RegWrite}.
REQ-010 SHALL have ports wb_we in 1, wb_reg in REGW, wb_data in XLEN: writeback-stage forwarding source.
REQ-011 SHALL have port flush  in  1  discard output register and abort the multiply in flight.
REQ-012 SHALL have ports out_valid out 1 / out_ready in 1: memory-side handshake.
REQ-013 SHALL have outputs result, store_data, br_target (XLEN), zero (1), out_ctl (5), out_rd (REGW), all registered.

Function
REQ-014 SHALL accept an instruction when in_valid && in_ready; in_ready = (state==RUN) && (!out_valid || out_ready) && !flush.
REQ-015 SHALL forward operand A: out_valid && out_ctl[0] && out_rd!=0 && out_rd==rs_a selects result; else wb_we && wb_reg!=0 && wb_reg==rs_a selects wb_data; else rd_a_data.
REQ-016 SHALL forward operand B (before the alu_src mux) with the identical rule on rs_b; the forwarded B also drives store_data.
REQ-017 SHALL compute ALU ops modulo 2^XLEN; SLT signed, result 1 or 0; undefined op codes behave as ADD.
REQ-018 SHALL compute br_target = pc + (imm << 2), truncated to XLEN; zero = (ALU/MUL result == 0).
REQ-019 SHALL load non-MUL results into the output register on the accepting edge (latency 1); out_valid set.
REQ-020 SHALL hold all outputs stable while out_valid && !out_ready; out_valid clears on out_ready with no new load.
REQ-021 SHALL implement FSM RUN/MUL: accepting op 0100 enters MUL, latches forwarded operands, counter = XLEN.
REQ-022 SHALL in MUL perform one shift-add step per cycle (low XLEN product bits); at counter 0 load output register, set out_valid, return to RUN; total latency XLEN+1.
REQ-023 SHALL on flush clear out_valid, force RUN, discard latched multiply; flush wins over any same-cycle acceptance or MUL completion.
REQ-024 SHALL treat a MUL completing while the output register holds unconsumed data as waiting in MUL until out_ready.

Reset
REQ-025 SHALL on reset low clear out_valid, result, store_data, br_target, zero, out_ctl, out_rd, counter to 0 and state to RUN, immediately and independent of clk.
REQ-026 SHALL, when reset asserts mid-multiply, abandon it; after release in_ready is 1 on the first edge.

Configuration
REQ-027 SHALL compile the MUL FSM and multiplier only when EXEC_MUL_EN is defined.
REQ-028 SHALL, without EXEC_MUL_EN, treat op 0100 as ADD with latency 1 and never leave RUN.

Verification
REQ-029 ADD rd_a=5, imm=7, alu_src=1 -> next edge result=12, out_valid=1, zero=0.
REQ-030 Back-to-back: r3=ADD(10,20), then SUB rs_a=3 with rd_b_data=30 -> result=0, zero=1 via output-register forwarding.
REQ-031 wb_we=1, wb_reg=4, wb_data=9 and out_rd=4 with result=2, RegWrite set; rs_a=4 ADD imm 0 -> result=2 (stage-3 priority).
REQ-032 EXEC_MUL_EN, XLEN=32: MUL 0xFFFF_FFFF * 3 -> in_ready=0 for 32 cycles, result=0xFFFF_FFFD at cycle 33.
REQ-033 flush at cycle 10 of a MUL -> out_valid=0, state RUN, in_ready=1 next cycle; no result emitted.
REQ-034 out_ready=0 holding result=12; new in_valid -> in_ready=0, outputs unchanged until out_ready=1.
